// File: rtl/ovl_window_arb_pkg.sv
// ovl_window_arb_pkg: shared constants for the window arbiter slice.
// New-start action codes, FSM encoding, parameter legality check.
package ovl_window_arb_pkg;

    localparam int IGNORE = 0;
    localparam int RESET  = 1;
    localparam int ERROR  = 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OPEN = 1'b1;

    // Window length must fit the counter and be at least one cycle.
    function automatic logic cfg_illegal(
        input int cks,
        input int act,
        input int cw
    );
        longint lim;
        lim = longint'(1) << cw;
        return (cks < 1) || (act < 0) || (act > 2) ||
               (longint'(cks) >= lim);
    endfunction

endpackage

// File: rtl/ovl_rr_pick.sv
// ovl_rr_pick: combinational round-robin picker.
// Ports: req, rr_ptr in; pick_oh (one-hot), pick_idx, pick_any out.
module ovl_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] rr_ptr,
    output logic [N-1:0] pick_oh,
    output logic [W-1:0] pick_idx,
    output logic         pick_any
);

    // Walk from farthest to nearest so the nearest hit
    // above rr_ptr is the last one written.
    always_comb begin
        int j;
        j        = 0;
        pick_oh  = '0;
        pick_idx = '0;
        for (int i = N; i >= 1; i--) begin
            j = (int'(rr_ptr) + i) % N;
            for (int k = 0; k < N; k++) begin
                if (k == j && req[k]) begin
                    pick_oh    = '0;
                    pick_oh[k] = 1'b1;
                    pick_idx   = W'(k);
                end
            end
        end
    end

    assign pick_any = |req;

endmodule

// File: rtl/ovl_window_arbiter.sv
// ovl_window_arbiter: shares one num_cks-cycle window among num_req
// start requesters, round-robin, with the new-start action policy.
// Ports: clk, reset_n (async low), enable, start_req[num_req] in;
//   window, window_owner, window_close, grant, pending,
//   new_start_err, cfg_error, starve_err out.
// Option: OVL_WINDOW_ARB_STARVE_EN builds per-requester
//   starvation counters; otherwise starve_err is tied to 0.
module ovl_window_arbiter
    import ovl_window_arb_pkg::*;
#(
    parameter int num_req             = 4,
    parameter int idx_width           = 2,
    parameter int num_cks             = 2,
    parameter int cnt_width           = 16,
    parameter int action_on_new_start = 0,
    parameter int starve_limit        = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic [num_req-1:0]   start_req,
    output logic                 window,
    output logic [idx_width-1:0] window_owner,
    output logic                 window_close,
    output logic [num_req-1:0]   grant,
    output logic [num_req-1:0]   pending,
    output logic                 new_start_err,
    output logic                 cfg_error,
    output logic [num_req-1:0]   starve_err
);

    localparam logic [cnt_width-1:0] CKS = cnt_width'(num_cks);
    localparam logic [cnt_width-1:0] ONE = cnt_width'(1);
    localparam logic [idx_width-1:0] PTR_INIT = idx_width'(num_req - 1);
    localparam logic [num_req-1:0]   BIT0 = num_req'(1);

    logic [0:0]           state;
    logic [cnt_width-1:0] cnt;
    logic [idx_width-1:0] rr_ptr;

    logic                 open;
    logic                 closing;
    logic [num_req-1:0]   own_oh;
    logic                 owner_start;
    logic                 reload;
    logic [num_req-1:0]   req;
    logic [num_req-1:0]   pick_oh;
    logic [idx_width-1:0] pick_idx;
    logic                 pick_any;
    logic                 take;

    assign cfg_error    = cfg_illegal(num_cks, action_on_new_start,
                                      cnt_width);
    assign open         = (state == OPEN);
    assign window       = open;
    assign closing      = open && (cnt == ONE);
    assign window_close = closing;

    // The owner's own start is handled by the action policy,
    // never queued as a fresh request.
    assign own_oh      = open ? (BIT0 << window_owner) : '0;
    assign owner_start = |(start_req & own_oh);
    assign req         = pending | (start_req & ~own_oh);
    assign reload      = owner_start && (action_on_new_start == RESET);

    // A reload on the close cycle keeps the window with its owner.
    assign take = !cfg_error && enable && pick_any &&
                  (!open || (closing && !reload));

    ovl_rr_pick #(
        .N (num_req),
        .W (idx_width)
    ) u_pick (
        .req      (req),
        .rr_ptr   (rr_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            window_owner  <= '0;
            rr_ptr        <= PTR_INIT;
            grant         <= '0;
            pending       <= '0;
            new_start_err <= 1'b0;
        end else begin
            grant         <= '0;
            pending       <= req;
            new_start_err <= owner_start &&
                             (action_on_new_start == ERROR);
            if (take) begin
                state        <= OPEN;
                cnt          <= CKS;
                window_owner <= pick_idx;
                rr_ptr       <= pick_idx;
                grant        <= pick_oh;
                pending      <= req & ~pick_oh;
            end else if (open) begin
                if (reload) begin
                    cnt <= CKS;
                end else begin
                    cnt <= cnt - ONE;
                    if (closing)
                        state <= IDLE;
                end
            end
        end
    end

`ifdef OVL_WINDOW_ARB_STARVE_EN
    localparam int SW = (starve_limit < 1) ? 1 :
                        $clog2(starve_limit + 1);
    localparam logic [SW-1:0] LIM = SW'(starve_limit);

    for (genvar i = 0; i < num_req; i++) begin : g_starve
        logic [SW-1:0] wcnt;
        logic          hit;

        // Counts pending cycles; saturates at the limit so the
        // error fires exactly once per wait.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wcnt <= '0;
                hit  <= 1'b0;
            end else if (!pending[i]) begin
                wcnt <= '0;
                hit  <= 1'b0;
            end else if (wcnt == LIM) begin
                hit  <= 1'b0;
            end else begin
                wcnt <= wcnt + SW'(1);
                hit  <= (wcnt + SW'(1)) == LIM;
            end
        end

        assign starve_err[i] = hit;
    end
`else
    localparam int unused_starve_limit = starve_limit;
    assign starve_err = '0;
`endif

endmodule

// File: tb/tb_ovl_window_arbiter.sv
// tb_ovl_window_arbiter: scoreboard bench over four configurations
// (cks3/ignore, cks2/reset, cks2/error, illegal num_cks=0).
module tb_ovl_window_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] sr  [4];
    logic       en  [4];
    logic       win [4];
    logic [1:0] own [4];
    logic       cls [4];
    logic [3:0] gnt [4];
    logic [3:0] pnd [4];
    logic [3:0] stv [4];
    logic       nse [4];
    logic       cfg [4];

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    ovl_window_arbiter #(
        .num_cks(3), .action_on_new_start(0), .starve_limit(4)
    ) u_a (
        .clk(clk), .reset_n(reset_n), .enable(en[0]),
        .start_req(sr[0]), .window(win[0]), .window_owner(own[0]),
        .window_close(cls[0]), .grant(gnt[0]), .pending(pnd[0]),
        .new_start_err(nse[0]), .cfg_error(cfg[0]),
        .starve_err(stv[0])
    );

    ovl_window_arbiter #(
        .num_cks(2), .action_on_new_start(1)
    ) u_b (
        .clk(clk), .reset_n(reset_n), .enable(en[1]),
        .start_req(sr[1]), .window(win[1]), .window_owner(own[1]),
        .window_close(cls[1]), .grant(gnt[1]), .pending(pnd[1]),
        .new_start_err(nse[1]), .cfg_error(cfg[1]),
        .starve_err(stv[1])
    );

    ovl_window_arbiter #(
        .num_cks(2), .action_on_new_start(2)
    ) u_c (
        .clk(clk), .reset_n(reset_n), .enable(en[2]),
        .start_req(sr[2]), .window(win[2]), .window_owner(own[2]),
        .window_close(cls[2]), .grant(gnt[2]), .pending(pnd[2]),
        .new_start_err(nse[2]), .cfg_error(cfg[2]),
        .starve_err(stv[2])
    );

    ovl_window_arbiter #(
        .num_cks(0), .action_on_new_start(0)
    ) u_d (
        .clk(clk), .reset_n(reset_n), .enable(en[3]),
        .start_req(sr[3]), .window(win[3]), .window_owner(own[3]),
        .window_close(cls[3]), .grant(gnt[3]), .pending(pnd[3]),
        .new_start_err(nse[3]), .cfg_error(cfg[3]),
        .starve_err(stv[3])
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] obs(input int d);
        return {3'b0, nse[d], cls[d], win[d], own[d], gnt[d], pnd[d]};
    endfunction

    function automatic logic [15:0] ev(
        input logic n, input logic c, input logic w,
        input logic [1:0] o, input logic [3:0] g, input logic [3:0] p
    );
        return {3'b0, n, c, w, o, g, p};
    endfunction

    // Drive one cycle of stimulus, queue the state expected after
    // the next edge, then compare it at the following negedge.
    task automatic cyc(input int d, input logic [3:0] s,
                       input logic e, input logic [15:0] x,
                       input string tag);
        sr[d] = s;
        en[d] = e;
        exp_q.push_back(x);
        @(negedge clk);
        chk(tag, 32'(obs(d)), 32'(exp_q.pop_front()));
    endtask

    initial begin
        reset_n = 1'b0;
        for (int d = 0; d < 4; d++) begin
            sr[d] = 4'b0;
            en[d] = 1'b1;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int d = 0; d < 4; d++)
            chk("reset", 32'(obs(d)), 32'h0);
        chk("stv_rst", 32'(stv[0]), 32'h0);
        chk("cfg_ok", 32'(cfg[0]), 32'h0);
        chk("cfg_bad", 32'(cfg[3]), 32'h1);

        // single request, 3-cycle window
        cyc(0, 4'b0001, 1, ev(0, 0, 1, 0, 4'b0001, 0), "t1_c1");
        cyc(0, 4'b0000, 1, ev(0, 0, 1, 0, 4'b0000, 0), "t1_c2");
        cyc(0, 4'b0000, 1, ev(0, 1, 1, 0, 4'b0000, 0), "t1_c3");
        cyc(0, 4'b0000, 1, ev(0, 0, 0, 0, 4'b0000, 0), "t1_c4");

        // contention 1011, back-to-back grants 0,1,3
        cyc(1, 4'b1011, 1, ev(0, 0, 1, 0, 4'b0001, 4'b1010), "t2_c1");
        cyc(1, 4'b0000, 1, ev(0, 1, 1, 0, 4'b0000, 4'b1010), "t2_c2");
        cyc(1, 4'b0000, 1, ev(0, 0, 1, 1, 4'b0010, 4'b1000), "t2_c3");
        cyc(1, 4'b0000, 1, ev(0, 1, 1, 1, 4'b0000, 4'b1000), "t2_c4");
        cyc(1, 4'b0000, 1, ev(0, 0, 1, 3, 4'b1000, 4'b0000), "t2_c5");
        cyc(1, 4'b0000, 1, ev(0, 1, 1, 3, 4'b0000, 4'b0000), "t2_c6");
        cyc(1, 4'b0000, 1, ev(0, 0, 0, 3, 4'b0000, 4'b0000), "t2_c7");

        // owner restarts on its close cycle: window reloads
        cyc(1, 4'b0001, 1, ev(0, 0, 1, 0, 4'b0001, 0), "t3_c1");
        cyc(1, 4'b0000, 1, ev(0, 1, 1, 0, 4'b0000, 0), "t3_c2");
        cyc(1, 4'b0001, 1, ev(0, 0, 1, 0, 4'b0000, 0), "t3_c3");
        cyc(1, 4'b0000, 1, ev(0, 1, 1, 0, 4'b0000, 0), "t3_c4");
        cyc(1, 4'b0000, 1, ev(0, 0, 0, 0, 4'b0000, 0), "t3_c5");

        // owner restarts mid-window: error pulse, same length
        cyc(2, 4'b0001, 1, ev(0, 0, 1, 0, 4'b0001, 0), "t4_c1");
        cyc(2, 4'b0001, 1, ev(1, 1, 1, 0, 4'b0000, 0), "t4_c2");
        cyc(2, 4'b0000, 1, ev(0, 0, 0, 0, 4'b0000, 0), "t4_c3");

        // enable low holds request pending, then grants
        cyc(0, 4'b0100, 0, ev(0, 0, 0, 0, 4'b0000, 4'b0100), "t5_c1");
        cyc(0, 4'b0000, 0, ev(0, 0, 0, 0, 4'b0000, 4'b0100), "t5_c2");
        cyc(0, 4'b0000, 1, ev(0, 0, 1, 2, 4'b0100, 4'b0000), "t5_c3");
        cyc(0, 4'b1000, 1, ev(0, 0, 1, 2, 4'b0000, 4'b1000), "t5_c4");

        // async reset mid-window
        sr[0] = 4'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_obs", 32'(obs(0)), 32'h0);
        chk("arst_cnt", 32'(u_a.cnt), 32'h0);
        #3;
        reset_n = 1'b1;
        @(negedge clk);

        // starvation: requester 2 pending with enable low
        sr[0] = 4'b0100;
        en[0] = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            sr[0] = 4'b0;
`ifdef OVL_WINDOW_ARB_STARVE_EN
            chk("starve", 32'(stv[0]),
                (k == 5) ? 32'h4 : 32'h0);
`else
            chk("starve_off", 32'(stv[0]), 32'h0);
`endif
        end

        // illegal config never grants
        sr[3] = 4'b0001;
        en[3] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("cfg_nogrant", 32'({win[3], gnt[3]}), 32'h0);
        end
        sr[3] = 4'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ovl_window_arbiter.md
Name: ovl_window_arbiter

Overview:
Shares a single "unchange" observation window (a num_cks-cycle counter-timed window) among num_req independent start-event requesters.
- Pends start requests.
- Grants the window round-robin.
- Applies the action-on-new-start policy to the current owner.
- Exports window, owner index and window_close to the downstream checker, assert and cover logic.
- Sits in the checker library in front of the per-window property logic.

Parameters:
num_req, 4, number of requesters (2..16)
idx_width, 2, owner index width; must satisfy 2**idx_width >= num_req
num_cks, 2, window length in cycles; must be >= 1
cnt_width, 16, window counter width
action_on_new_start, 0, 0 = ignore, 1 = reset window, 2 = error
starve_limit, 64, max pending cycles before starve_err; used only with the optional feature

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous, active-low
enable  in  1  permits new grants
start_req  in  num_req  per-requester start event, level-sampled
window  out  1  window open
window_owner  out  idx_width  index of the requester owning the window
window_close  out  1  combinational: window && cnt == 1
grant  out  num_req  one-hot pulse in the first cycle of each granted window
pending  out  num_req  queued, ungranted requests
new_start_err  out  1  pulse; owner restarted while action_on_new_start = 2
cfg_error  out  1  static; illegal parameters
starve_err  out  num_req  per-requester starvation pulse; tied to 0 without the optional feature

Behaviour:
- Reset (async assert, sync release). All of the following clear to 0: window, cnt, window_owner, grant, pending, new_start_err, starve_err. rr_ptr is set to num_req-1.
- cfg_error = (num_cks < 1) || (action_on_new_start > 2) || (num_cks >= 2**cnt_width). When it is 1, the FSM is held in IDLE and no grants are issued.
- FSM states: IDLE, OPEN.
- Request set: req = pending | start_req. In OPEN, the owner's own start_req is excluded from req.
- Pick rule: first set bit of req searching upward from rr_ptr+1, wrapping modulo num_req.
- IDLE, with req != 0 and enable = 1, at edge t:
  - window <= 1; cnt <= num_cks; window_owner <= pick; rr_ptr <= pick.
  - grant[pick] is high during cycle t+1.
  - pending <= req with the pick bit cleared.
  - Latency: start_req sampled at edge t produces window high from t+1.
- OPEN, each edge: cnt <= cnt-1, unless a reset-on-new-start reload applies (see below).
  - On the close cycle (cnt == 1), with enable = 1 and req != 0: re-grant back-to-back. window stays 1, new owner, cnt = num_cks, grant pulses.
  - On the close cycle otherwise: go to IDLE, window <= 0.
- Owner start_req during OPEN:
  - action 0: dropped; not pended.
  - action 1: cnt <= num_cks, including on the close cycle, so the window stays open and no re-grant occurs.
  - action 2: new_start_err pulses for one cycle at t+1; the window continues unchanged.
- Non-owner start_req during OPEN: OR'd into pending. Duplicates collapse into one pending bit.
- enable low: no grants, in IDLE or on the close cycle. An open window runs to completion. pending keeps accumulating.
- num_cks = 1: window is exactly one cycle; window_close is high the same cycle as window.
- Reset asserted mid-window: everything clears immediately; pending requests are lost.

Optional Feature:
OVL_WINDOW_ARB_STARVE_EN
- Defined: each requester has a wait counter.
  - Clears when the pending bit is 0 or when granted.
  - Increments while pending.
  - When the count reaches starve_limit, starve_err[i] pulses once and the counter saturates until grant.
- Undefined: no counters are built; starve_err = 0.

Decomposition:
- Shared package ovl_window_arb_pkg holds:
  - action encodings: IGNORE = 0, RESET = 1, ERROR = 2 (same values as the library's new-start constants);
  - FSM state encoding IDLE/OPEN;
  - the parameter legality function.
- Sub-module ovl_rr_pick: combinational round-robin picker. Inputs req and rr_ptr; outputs one-hot and index. Reused by other shared-checker schedulers.

Test Plan:
- Single request, num_cks = 3: start_req = 0001 at edge 0 -> window high cycles 1–3, owner = 0, grant[0] in cycle 1, window_close in cycle 3.
- Contention: start_req = 1011 for one cycle, num_cks = 2 -> owners 0, 1, 3 back-to-back with window continuously high for 6 cycles, then IDLE; pending seen as 1010, 1000, 0000.
- Reset-on-new-start (action 1, num_cks = 2): owner 0 re-raises start at its close cycle -> window extends 2 more cycles; no grant pulse.
- Error-on-new-start (action 2): owner re-raises mid-window -> new_start_err single pulse; window length unchanged.
- enable = 0 with start_req = 0100 -> no window while enable is low, pending = 0100; enable rises -> grant next edge. Async reset mid-window -> window, pending and cnt are 0 immediately.
- With OVL_WINDOW_ARB_STARVE_EN, starve_limit = 4, enable = 0, requester 2 pending -> starve_err[2] pulses once after 4 cycles. Bad num_cks = 0 -> cfg_error = 1 and no grants.
